// File: rtl/ngp_pkg.sv
// Shared types and constants for the NandGame+ instruction-memory loader.
package ngp_pkg;

  localparam int WORD_W = 16;
  localparam logic [WORD_W-1:0] NGP_FILL_DEFAULT = 16'h0000;

  typedef enum logic [2:0] {
    LD_IDLE,
    LD_LEN_LO,
    LD_LEN_HI,
    LD_DATA_LO,
    LD_DATA_HI,
    LD_RUN
  } ngp_ld_state_t;

endpackage

// File: rtl/ngp_imem_loader_if.sv
// Byte-stream load port: start pulse plus valid/ready byte handshake.
interface ngp_imem_loader_if;

  logic       ld_start;
  logic       ld_valid;
  logic [7:0] ld_byte;
  logic       ld_ready;

  modport master (output ld_start, output ld_valid, output ld_byte, input ld_ready);
  modport slave  (input ld_start, input ld_valid, input ld_byte, output ld_ready);

endinterface

// File: rtl/ngp_imem_array.sv
// Instruction word storage: one synchronous write port, one asynchronous read port.
module ngp_imem_array
  import ngp_pkg::*;
#(
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned AW    = 10
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [WORD_W-1:0] wdata_i,
  input  logic [AW-1:0]     raddr_i,
  output logic [WORD_W-1:0] rdata_o
);

  logic [WORD_W-1:0] mem_q [DEPTH];

  // Contents deliberately survive reset; only a completed load makes them visible.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/ngp_imem_loader.sv
// Instruction memory for the NandGame+ core with a length-prefixed byte loader that holds the core in reset.
module ngp_imem_loader
  import ngp_pkg::*;
#(
  parameter int unsigned       DEPTH = 1024,
  parameter logic [WORD_W-1:0] FILL  = NGP_FILL_DEFAULT
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [15:0]             addr_i,
  output logic [WORD_W-1:0]       instruction_o,
  output logic                    core_hold_o,
  ngp_imem_loader_if.slave        ld,
  output logic                    ld_err_o,
  output logic [15:0]             ld_words_o
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  ngp_ld_state_t     state_q, state_d;
  logic [15:0]       len_q, len_d;
  logic [7:0]        lo_q, lo_d;
  logic [15:0]       words_q, words_d;
  logic              err_q, err_d;
  logic              hold_q, hold_d;

  logic              accept;
  logic [15:0]       len_rx;
  logic [15:0]       words_inc;
  logic              we;
  logic [WORD_W-1:0] wdata;
  logic [WORD_W-1:0] rdata;
  logic              in_range;

  assign ld.ld_ready = (state_q == LD_LEN_LO)  || (state_q == LD_LEN_HI) ||
                       (state_q == LD_DATA_LO) || (state_q == LD_DATA_HI);
  assign accept    = ld.ld_valid && ld.ld_ready;
  assign len_rx    = {ld.ld_byte, len_q[7:0]};
  assign words_inc = words_q + 16'd1;
  assign wdata     = {ld.ld_byte, lo_q};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= LD_IDLE;
      len_q   <= '0;
      lo_q    <= '0;
      words_q <= '0;
      err_q   <= 1'b0;
      hold_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      lo_q    <= lo_d;
      words_q <= words_d;
      err_q   <= err_d;
      hold_q  <= hold_d;
    end
  end

  // A start pulse wins over any byte offered in the same cycle; that byte is dropped.
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    lo_d    = lo_q;
    words_d = words_q;
    err_d   = err_q;
    hold_d  = hold_q;
    we      = 1'b0;

    if (ld.ld_start) begin
      state_d = LD_LEN_LO;
      hold_d  = 1'b1;
      err_d   = 1'b0;
      words_d = '0;
    end else begin
      unique case (state_q)
        LD_IDLE: hold_d = 1'b1;
        LD_LEN_LO: begin
          if (accept) begin
            len_d[7:0] = ld.ld_byte;
            state_d    = LD_LEN_HI;
          end
        end
        LD_LEN_HI: begin
          if (accept) begin
            len_d = len_rx;
            if (len_rx == 16'd0) begin
              state_d = LD_RUN;
              hold_d  = 1'b0;
            end else if ({16'd0, len_rx} > 32'(DEPTH)) begin
              err_d   = 1'b1;
              state_d = LD_IDLE;
            end else begin
              state_d = LD_DATA_LO;
            end
          end
        end
        LD_DATA_LO: begin
          if (accept) begin
            lo_d    = ld.ld_byte;
            state_d = LD_DATA_HI;
          end
        end
        LD_DATA_HI: begin
          if (accept) begin
            we      = 1'b1;
            words_d = words_inc;
            if (words_inc == len_q) begin
              state_d = LD_RUN;
              hold_d  = 1'b0;
            end else begin
              state_d = LD_DATA_LO;
            end
          end
        end
        LD_RUN: hold_d = 1'b0;
        default: state_d = LD_IDLE;
      endcase
    end
  end

  ngp_imem_array #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_array (
    .clk     (clk),
    .we_i    (we),
    .waddr_i (words_q[AW-1:0]),
    .wdata_i (wdata),
    .raddr_i (addr_i[AW-1:0]),
    .rdata_o (rdata)
  );

  // Fetch is combinational so the core sees the word in the same cycle its address changes.
  assign in_range      = {16'd0, addr_i} < 32'(DEPTH);
  assign instruction_o = ((state_q == LD_RUN) && in_range) ? rdata : FILL;

  assign core_hold_o = hold_q;
  assign ld_err_o    = err_q;
  assign ld_words_o  = words_q;

endmodule

// File: tb/tb_ngp_imem_loader.sv
// Randomized self-checking bench for ngp_imem_loader against a program-level memory model.
module tb_ngp_imem_loader;

  localparam int          TB_DEPTH = 1024;
  localparam logic [15:0] TB_FILL  = 16'hF00D;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] addr;
  logic [15:0] instr;
  logic        coreHold;
  logic        ldErr;
  logic [15:0] ldWords;

  ngp_imem_loader_if ldIf ();

  ngp_imem_loader #(
    .DEPTH (TB_DEPTH),
    .FILL  (TB_FILL)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .addr_i        (addr),
    .instruction_o (instr),
    .core_hold_o   (coreHold),
    .ld            (ldIf),
    .ld_err_o      (ldErr),
    .ld_words_o    (ldWords)
  );

  always #5 clk = ~clk;

  // Model: what a completed load leaves visible to the core.
  logic [15:0] modelMem   [TB_DEPTH];
  bit          modelKnown [TB_DEPTH];
  bit          modelRunning;

  int          checksTotal  = 0;
  int          checksPassed = 0;
  logic [15:0] prog [$];
  logic [15:0] emptyProg [$];

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checksTotal++;
    if (observed !== expected) begin
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end else begin
      checksPassed++;
    end
  endtask

  // Offer one byte after an optional idle gap; returns #1 after the accepting edge.
  task automatic applyStimulus(input logic [7:0] b, input int gap);
    int waited = 0;
    for (int g = 0; g < gap; g++) begin
      ldIf.ld_valid = 1'b0;
      @(posedge clk); #1;
    end
    ldIf.ld_valid = 1'b1;
    ldIf.ld_byte  = b;
    while (!ldIf.ld_ready && waited < 20) begin
      @(posedge clk); #1;
      waited++;
    end
    if (!ldIf.ld_ready) checkOutput("ready_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    ldIf.ld_valid = 1'b0;
  endtask

  task automatic pulseStart(input bit withValid);
    ldIf.ld_start = 1'b1;
    ldIf.ld_valid = withValid;
    ldIf.ld_byte  = 8'h5A;
    @(posedge clk); #1;
    ldIf.ld_start = 1'b0;
    ldIf.ld_valid = 1'b0;
    modelRunning  = 1'b0;
    checkOutput("hold_after_start", 32'(coreHold), 32'd1);
    checkOutput("words_after_start", 32'(ldWords), 32'd0);
    checkOutput("err_after_start", 32'(ldErr), 32'd0);
  endtask

  task automatic checkFetch(input string tag, input logic [15:0] a);
    addr = a;
    #1;
    if (!modelRunning || a >= TB_DEPTH) begin
      checkOutput(tag, 32'(instr), 32'(TB_FILL));
    end else if (modelKnown[a]) begin
      checkOutput(tag, 32'(instr), 32'(modelMem[a]));
    end
  endtask

  task automatic loadProgram(input logic [15:0] words [$], input bit startWithValid, input int maxGap);
    logic [7:0]  bytesQ [$];
    logic [15:0] len;
    int          gap;
    len = 16'(words.size());
    bytesQ.push_back(len[7:0]);
    bytesQ.push_back(len[15:8]);
    foreach (words[i]) begin
      bytesQ.push_back(words[i][7:0]);
      bytesQ.push_back(words[i][15:8]);
    end
    pulseStart(startWithValid);
    foreach (bytesQ[i]) begin
      gap = (maxGap == 0) ? 0 : int'($urandom_range(1, maxGap));
      if (i == bytesQ.size() - 1) checkOutput("hold_before_last", 32'(coreHold), 32'd1);
      applyStimulus(bytesQ[i], gap);
    end
    checkOutput("hold_after_load", 32'(coreHold), 32'd0);
    checkOutput("words_after_load", 32'(ldWords), 32'(len));
    checkOutput("ready_in_run", 32'(ldIf.ld_ready), 32'd0);
    foreach (words[i]) begin
      modelMem[i]   = words[i];
      modelKnown[i] = 1'b1;
    end
    modelRunning = 1'b1;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    rst           = 1'b1;
    addr          = 16'd0;
    ldIf.ld_start = 1'b0;
    ldIf.ld_valid = 1'b0;
    ldIf.ld_byte  = 8'h00;
    modelRunning  = 1'b0;
    foreach (modelKnown[i]) modelKnown[i] = 1'b0;

    #12;
    checkOutput("rst_hold", 32'(coreHold), 32'd1);
    checkOutput("rst_ready", 32'(ldIf.ld_ready), 32'd0);
    checkOutput("rst_err", 32'(ldErr), 32'd0);
    checkOutput("rst_words", 32'(ldWords), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    checkOutput("idle_hold", 32'(coreHold), 32'd1);
    checkFetch("idle_fetch0", 16'd0);

    $display("[TB] preload 8 random words");
    prog.delete();
    for (int i = 0; i < 8; i++) prog.push_back(16'($urandom));
    loadProgram(prog, 1'b0, 0);
    for (int i = 0; i < 8; i++) checkFetch("preload_fetch", 16'(i));

    $display("[TB] basic load 03 00 34 12 78 56 BC 9A");
    prog = '{16'h1234, 16'h5678, 16'h9ABC};
    loadProgram(prog, 1'b0, 0);
    checkFetch("basic_fetch0", 16'd0);
    checkFetch("basic_fetch1", 16'd1);
    checkFetch("basic_fetch2", 16'd2);
    checkFetch("basic_fetch3_prior", 16'd3);
    checkFetch("basic_fetch_oob", 16'd1024);
    checkFetch("basic_fetch_max", 16'hFFFF);

    $display("[TB] over-length 01 04");
    pulseStart(1'b0);
    applyStimulus(8'h01, 0);
    applyStimulus(8'h04, 0);
    checkOutput("ovl_err", 32'(ldErr), 32'd1);
    checkOutput("ovl_ready", 32'(ldIf.ld_ready), 32'd0);
    checkOutput("ovl_hold", 32'(coreHold), 32'd1);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("ovl_err_sticky", 32'(ldErr), 32'd1);
    checkOutput("ovl_hold_stays", 32'(coreHold), 32'd1);
    checkFetch("ovl_fetch0", 16'd0);

    $display("[TB] zero length");
    loadProgram(emptyProg, 1'b0, 0);
    checkOutput("zero_err_cleared", 32'(ldErr), 32'd0);

    $display("[TB] 4-word load, gapless then with gaps");
    prog.delete();
    for (int i = 0; i < 4; i++) prog.push_back(16'($urandom));
    loadProgram(prog, 1'b0, 0);
    for (int i = 0; i < 4; i++) checkFetch("nogap_fetch", 16'(i));
    loadProgram(prog, 1'b0, 5);
    for (int i = 0; i < 4; i++) checkFetch("gap_fetch", 16'(i));

    $display("[TB] randomized loads");
    for (int r = 0; r < 4; r++) begin
      n = int'($urandom_range(1, 12));
      prog.delete();
      for (int i = 0; i < n; i++) prog.push_back(16'($urandom));
      loadProgram(prog, 1'b0, r);
      for (int k = 0; k < 4; k++) checkFetch("rand_fetch", 16'($urandom_range(0, n - 1)));
      checkFetch("rand_fetch_oob", 16'($urandom_range(TB_DEPTH, 16'hFFFF)));
    end

    $display("[TB] start with byte offered mid-LEN_HI, then reload while running");
    pulseStart(1'b0);
    applyStimulus(8'h02, 0);
    loadProgram(emptyProg, 1'b1, 0);
    prog = '{16'hBEEF};
    loadProgram(prog, 1'b1, 0);
    checkFetch("reload_fetch0", 16'd0);

    $display("[TB] async reset mid DATA_HI");
    pulseStart(1'b0);
    applyStimulus(8'h02, 0);
    applyStimulus(8'h00, 0);
    applyStimulus(8'h11, 0);
    checkOutput("datahi_ready", 32'(ldIf.ld_ready), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("async_rst_hold", 32'(coreHold), 32'd1);
    checkOutput("async_rst_ready", 32'(ldIf.ld_ready), 32'd0);
    checkOutput("async_rst_words", 32'(ldWords), 32'd0);
    #2;
    rst = 1'b0;
    modelRunning = 1'b0;
    @(posedge clk); #1;
    checkFetch("post_rst_fetch0", 16'd0);

    $display("%0d/%0d checks passed", checksPassed, checksTotal);
    $finish;
  end

endmodule

// File: doc/ngp_imem_loader.md
# ngp_imem_loader

Instruction-memory responder for the NandGame+ core: it answers the core's fetch address with a 16-bit instruction word in the same cycle. It also owns the program-load side, accepting a length-prefixed byte stream over a valid/ready port, writing it into the array, and holding the core in reset until a complete program is resident. It sits between the core's `addr`/`instruction` pair and the board-level loader (UART bridge or testbench).

## Interface
- `DEPTH`, default 1024: instruction words stored. Power of two, at most 65536.
- `FILL`, default 16'h0000: word returned for out-of-range or held fetches.
- `clk` in 1: single clock.
- `rst` in 1: asynchronous, active-high reset.
- `addr` in 16: fetch address from the core.
- `instruction` out 16: fetched word to the core.
- `core_hold` out 1: high keeps the core in reset. The top level drives the core's `_rst` from `~core_hold`.
- `ld_start` in 1: one-cycle pulse that begins a new load.
- `ld_valid` in 1: a byte is offered.
- `ld_byte` in 8: the offered byte.
- `ld_ready` out 1: the block accepts a byte this cycle.
- `ld_err` out 1: sticky error flag; the length exceeded `DEPTH`.
- `ld_words` out 16: number of words written by the last or current load.

## Operation
- States: IDLE, LEN_LO, LEN_HI, DATA_LO, DATA_HI, RUN.
- Reset values: state IDLE, `core_hold`=1, `ld_ready`=0, `ld_err`=0, `ld_words`=0. Array contents are not cleared.
- A byte is accepted when `ld_valid && ld_ready`. `ld_ready` is high in LEN_LO, LEN_HI, DATA_LO and DATA_HI only.
- `ld_start` in any state: go to LEN_LO, set `core_hold`=1, clear `ld_err`, clear `ld_words`. `ld_start` has priority over a byte accepted in the same cycle; that byte is dropped.
- LEN_LO: accept byte as len[7:0], go to LEN_HI.
- LEN_HI: accept byte as len[15:8].
  - len==0: go to RUN.
  - len>DEPTH: set `ld_err`, go to IDLE.
  - Otherwise: go to DATA_LO.
- DATA_LO: latch the low byte, go to DATA_HI.
- DATA_HI: on accept, write {byte, low} to array[`ld_words`] on that edge and increment `ld_words`.
  - If the new `ld_words`==len, go to RUN.
  - Otherwise go back to DATA_LO.
- RUN: `core_hold`=0.
- IDLE: `core_hold`=1. The only exit is `ld_start`.
- Fetch, combinational from `addr`:
  - `instruction` = array[addr] when state is RUN and addr<DEPTH.
  - Otherwise `instruction` = `FILL`.
- Byte order is little-endian. The first data word goes to address 0, and addresses rise by 1.

## Timing
- Fetch latency is zero cycles, because the core consumes `instruction` in the same cycle its `addr` register updates. The read must be asynchronous.
- `core_hold` is registered. It falls on the edge after the final DATA_HI accept; that is the same edge on which the last word is written.
- Because of that, the core's first fetch (addr 0) sees the complete program.
- `core_hold` rises on the edge that samples `ld_start`.
- There is no write/read hazard: writes happen only while held.
- Loader throughput is one byte per cycle with `ld_valid` held high, so an N-word program takes 2+2N accept cycles.
- Reset mid-load: returns to IDLE immediately. Partially written words stay in the array but are unreachable until a new load completes.
- `ld_words` wraps never; it is bounded by `DEPTH`.

## Structure
- Shared package `ngp_pkg` holds:
  - `WORD_W`=16
  - the loader state enum `ngp_ld_state_t`
  - `NGP_FILL_DEFAULT`
- Sub-module `ngp_imem_array`:
  - `DEPTH`×16 register array
  - one synchronous write port (we, waddr, wdata)
  - one asynchronous read port
  - no reset on contents

## Test plan
- Basic load: reset, `ld_start`, stream 03 00 34 12 78 56 BC 9A.
  - `core_hold` falls one cycle after the last byte and `ld_words`=3.
  - Fetches of addr 0/1/2 return 1234/5678/9ABC; addr 3 returns prior contents.
- Over-length: with `DEPTH`=1024, send length bytes 01 04 (1025).
  - `ld_err`=1, state IDLE, `ld_ready`=0, `core_hold` stays 1, and addr 0 returns `FILL`.
- Zero length: send 00 00. `core_hold` falls after the second byte and `ld_words`=0.
- Backpressure gaps: drop `ld_valid` randomly for 1–5 cycles between bytes of a 4-word load. The result must be identical to the gapless case.
- Reload while running:
  - Pulse `ld_start` with `ld_valid`=1 on the same cycle. That byte is ignored and `core_hold`=1 on the next cycle.
  - A 1-word load of EF BE then gives addr 0 = BEEF.
- Async reset mid-DATA_HI: assert `rst` between clock edges. `core_hold`=1 and `ld_ready`=0 immediately, without waiting for a clock edge.
